// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: the controller state encoding.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sa_state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit combinational full adder cell used as the serial adder's bit slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    // Classic sum/majority decomposition; purely combinational.
    always_comb begin
        sum   = a ^ b ^ c;
        carry = (a & b) | (c & (a ^ b));
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: captures operands on start, adds one bit per
// clock LSB first through a single full_adder, and reports the registered
// sum/carry-out together with a one-cycle done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sa_state_t state_q, state_d;

    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_out_q, sum_out_d;
    logic             cout_q, cout_d;

    logic             fa_sum;
    logic             fa_carry;
    logic             last_bit;
    logic [WIDTH-1:0] shifted_sum;

    full_adder u_full_adder (
        .a     (a_sr_q[0]),
        .b     (b_sr_q[0]),
        .c     (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    assign last_bit = (cnt_q == LAST_BIT);

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start is only looked at in IDLE, DONE always returns to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded straight from the registered state so they never glitch.
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    // Sum shift register after inserting the freshly computed bit at the MSB end.
    always_comb begin
        shifted_sum              = sum_sr_q >> 1;
        shifted_sum[WIDTH-1]     = fa_sum;
    end

    // Datapath next values; the result register is loaded on the edge that enters
    // DONE so that sum_out/cout are already valid while done is high.
    always_comb begin
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        sum_sr_d  = sum_sr_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        sum_out_d = sum_out_q;
        cout_d    = cout_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d   = a_in;
                    b_sr_d   = b_in;
                    carry_d  = cin;
                    cnt_d    = '0;
                    sum_sr_d = '0;
                end
            end
            SHIFT: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                sum_sr_d = shifted_sum;
                carry_d  = fa_carry;
                if (last_bit) begin
                    cnt_d     = '0;
                    sum_out_d = shifted_sum;
                    cout_d    = fa_carry;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
            end
            default: begin
            end
        endcase
    end

    // Datapath registers: shift regs, carry flop, bit counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            sum_sr_q  <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            sum_out_q <= '0;
            cout_q    <= 1'b0;
        end else begin
            a_sr_q    <= a_sr_d;
            b_sr_q    <= b_sr_d;
            sum_sr_q  <= sum_sr_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            sum_out_q <= sum_out_d;
            cout_q    <= cout_d;
        end
    end

    assign sum_out = sum_out_q;
    assign cout    = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8, 3 and 1.
module tb_serial_adder;

   typedef struct {
      int res;
      int cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;

   logic       start8;
   logic [7:0] a8, b8;
   logic       cin8;
   logic       busy8, done8, cout8;
   logic [7:0] sum8;

   logic       start3;
   logic [2:0] a3, b3;
   logic       cin3;
   logic       busy3, done3, cout3;
   logic [2:0] sum3;

   logic       start1;
   logic [0:0] a1, b1;
   logic       cin1;
   logic       busy1, done1, cout1;
   logic [0:0] sum1;

   exp_t q8[$];
   exp_t q3[$];
   exp_t q1[$];

   int cycleCnt = 0;
   int testsRun = 0;
   int testsFailed = 0;
   int resetReq = 0;
   int resetAck = 0;
   int endReq = 0;
   int endAck = 0;

   // Free-running 10 ns clock shared by all three adders.
   always #5 clk = ~clk;

   // Edge counter used to predict the exact cycle each done pulse should appear in.
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum_out(sum8), .cout(cout8)
   );

   serial_adder #(.WIDTH(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .a_in(a3), .b_in(b3), .cin(cin3),
      .busy(busy3), .done(done3), .sum_out(sum3), .cout(cout3)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum_out(sum1), .cout(cout1)
   );

   task automatic checkOutput(input string name, input int actual, input int expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Monitor: on the falling edge, compare every done pulse against the head of
   // that adder's expectation queue (value and arrival cycle), flag late or
   // spurious pulses, and service reset-state and end-of-run check requests.
   always @(negedge clk) begin
      exp_t e;
      if (resetAck != resetReq) begin
         checkOutput("reset busy8", int'(busy8), 0);
         checkOutput("reset done8", int'(done8), 0);
         checkOutput("reset sum8", int'(sum8), 0);
         checkOutput("reset cout8", int'(cout8), 0);
         checkOutput("reset busy3", int'(busy3), 0);
         checkOutput("reset done3", int'(done3), 0);
         checkOutput("reset sum3", int'({cout3, sum3}), 0);
         checkOutput("reset busy1", int'(busy1), 0);
         checkOutput("reset done1", int'(done1), 0);
         checkOutput("reset sum1", int'({cout1, sum1}), 0);
         resetAck = resetReq;
      end

      if (done8 === 1'b1) begin
         if (q8.size() == 0) checkOutput("w8 spurious done", 1, 0);
         else begin
            e = q8.pop_front();
            checkOutput("w8 result", int'({cout8, sum8}), e.res);
            checkOutput("w8 done cycle", cycleCnt, e.cyc);
         end
      end else if (q8.size() != 0 && cycleCnt > q8[0].cyc) begin
         e = q8.pop_front();
         checkOutput("w8 missing done", 0, 1);
      end

      if (done3 === 1'b1) begin
         if (q3.size() == 0) checkOutput("w3 spurious done", 1, 0);
         else begin
            e = q3.pop_front();
            checkOutput("w3 result", int'({cout3, sum3}), e.res);
            checkOutput("w3 done cycle", cycleCnt, e.cyc);
         end
      end else if (q3.size() != 0 && cycleCnt > q3[0].cyc) begin
         e = q3.pop_front();
         checkOutput("w3 missing done", 0, 1);
      end

      if (done1 === 1'b1) begin
         if (q1.size() == 0) checkOutput("w1 spurious done", 1, 0);
         else begin
            e = q1.pop_front();
            checkOutput("w1 result", int'({cout1, sum1}), e.res);
            checkOutput("w1 done cycle", cycleCnt, e.cyc);
         end
      end else if (q1.size() != 0 && cycleCnt > q1[0].cyc) begin
         e = q1.pop_front();
         checkOutput("w1 missing done", 0, 1);
      end

      if (endAck != endReq) begin
         checkOutput("w8 queue drained", q8.size(), 0);
         checkOutput("w3 queue drained", q3.size(), 0);
         checkOutput("w1 queue drained", q1.size(), 0);
         endAck = endReq;
      end
   end

   // Issue one add on the chosen adder and queue its expected result. Start is
   // accepted on the next edge, done follows w edges later, and the adder is back
   // in IDLE one edge after that, so the task returns w+2 edges after driving.
   // With hold set, start stays high and operands are scrambled while busy.
   task automatic applyStimulus(input int w, input int a, input int b, input int c, input bit hold);
      exp_t e;
      e.res = (a + b + c) & ((1 << (w + 1)) - 1);
      e.cyc = cycleCnt + 1 + w;
      case (w)
         8: begin a8 = 8'(a); b8 = 8'(b); cin8 = 1'(c); start8 = 1'b1; q8.push_back(e); end
         3: begin a3 = 3'(a); b3 = 3'(b); cin3 = 1'(c); start3 = 1'b1; q3.push_back(e); end
         default: begin a1 = 1'(a); b1 = 1'(b); cin1 = 1'(c); start1 = 1'b1; q1.push_back(e); end
      endcase
      @(posedge clk); #1;
      if (!hold) begin
         start8 = 1'b0; start3 = 1'b0; start1 = 1'b0;
      end
      repeat (w + 1) begin
         if (hold) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            a3 = 3'($urandom); b3 = 3'($urandom); cin3 = 1'($urandom);
            a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic waitDrain();
      int guard;
      guard = 0;
      while ((q8.size() != 0 || q3.size() != 0 || q1.size() != 0) && guard < 40) begin
         @(posedge clk);
         guard++;
      end
      @(posedge clk); #1;
   endtask

   task automatic requestResetCheck();
      resetReq++;
      @(negedge clk); #1;
   endtask

   // Main stimulus sequence.
   initial begin
      rst_n = 1'b0;
      start8 = 1'b0; start3 = 1'b0; start1 = 1'b0;
      a8 = '0; b8 = '0; cin8 = 1'b0;
      a3 = '0; b3 = '0; cin3 = 1'b0;
      a1 = '0; b1 = '0; cin1 = 1'b0;

      // Reset held three clocks with random activity on the inputs.
      repeat (3) begin
         start8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
         start3 = 1'($urandom); a3 = 3'($urandom); b3 = 3'($urandom); cin3 = 1'($urandom);
         start1 = 1'($urandom); a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
         @(posedge clk); #1;
      end
      requestResetCheck();
      start8 = 1'b0; start3 = 1'b0; start1 = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Basic add and carry-out boundaries on the 8-bit adder.
      applyStimulus(8, 100, 55, 0, 1'b0);
      applyStimulus(8, 255, 1, 0, 1'b0);
      applyStimulus(8, 165, 90, 1, 1'b0);
      applyStimulus(8, 0, 0, 0, 1'b0);
      applyStimulus(8, 255, 255, 1, 1'b0);
      waitDrain();

      // Start held high across back-to-back operations with noisy operands.
      applyStimulus(8, 18, 52, 0, 1'b1);
      applyStimulus(8, 200, 100, 1, 1'b1);
      applyStimulus(8, 7, 9, 1, 1'b1);
      start8 = 1'b0;
      waitDrain();

      // Abort an operation while it is on bit 4; no done may follow.
      a8 = 8'd1; b8 = 8'd2; cin8 = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      requestResetCheck();
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (12) begin @(posedge clk); #1; end
      applyStimulus(8, 77, 88, 1, 1'b0);
      waitDrain();

      // Exhaustive 3-bit and 1-bit sweeps.
      for (int a = 0; a < 8; a++)
         for (int b = 0; b < 8; b++)
            for (int c = 0; c < 2; c++)
               applyStimulus(3, a, b, c, 1'b0);
      waitDrain();
      for (int a = 0; a < 2; a++)
         for (int b = 0; b < 2; b++)
            for (int c = 0; c < 2; c++)
               applyStimulus(1, a, b, c, 1'b0);
      waitDrain();

      endReq++;
      @(negedge clk); #1;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
